// File: rtl/matmul_seq_scheduler.sv
// Sequencer that drives one shared dot-product unit to build an L x N matrix product
// one element at a time, in row-major order.
module matmul_seq_scheduler #(
    parameter int L       = 1,
    parameter int M       = 1,
    parameter int N       = 1,
    parameter int DOT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*L*M-1:0] A,
    input  logic [32*N*M-1:0] B_T,
    output logic              busy,
    output logic              done,
    output logic [32*M-1:0]   vec_a,
    output logic [32*M-1:0]   vec_b,
    input  logic [31:0]       dot_res,
    output logic [32*L*N-1:0] result
);

    localparam int CA_W = (L > 1) ? $clog2(L) : 1;
    localparam int CB_W = (N > 1) ? $clog2(N) : 1;
    localparam int WC_W = (DOT_LAT > 1) ? $clog2(DOT_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [32*L*M-1:0]   a_buf_q, a_buf_d;
    logic [32*N*M-1:0]   b_buf_q, b_buf_d;
    logic [32*M-1:0]     vec_a_q, vec_a_d;
    logic [32*M-1:0]     vec_b_q, vec_b_d;
    logic [32*L*N-1:0]   result_q, result_d;
    logic [CA_W-1:0]     cnt_a_q, cnt_a_d;
    logic [CB_W-1:0]     cnt_b_q, cnt_b_d;
    logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic                lat_reached;
    logic                last_elem;

    assign lat_reached = (wait_cnt_q == WC_W'(DOT_LAT - 1));
    assign last_elem   = (cnt_a_q == CA_W'(L - 1)) && (cnt_b_q == CB_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_buf_q    <= '0;
            b_buf_q    <= '0;
            vec_a_q    <= '0;
            vec_b_q    <= '0;
            result_q   <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_buf_q    <= a_buf_d;
            b_buf_q    <= b_buf_d;
            vec_a_q    <= vec_a_d;
            vec_b_q    <= vec_b_d;
            result_q   <= result_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = WAIT;
            WAIT:    if (lat_reached) state_d = last_elem ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates keyed on the current state; everything else holds.
    always_comb begin
        a_buf_d    = a_buf_q;
        b_buf_d    = b_buf_q;
        vec_a_d    = vec_a_q;
        vec_b_d    = vec_b_q;
        result_d   = result_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_buf_d  = A;
                    b_buf_d  = B_T;
                    result_d = '0;
                    cnt_a_d  = '0;
                    cnt_b_d  = '0;
                end
            end
            LOAD: begin
                vec_a_d    = a_buf_q[32*M*int'(cnt_a_q) +: 32*M];
                vec_b_d    = b_buf_q[32*M*int'(cnt_b_q) +: 32*M];
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (!lat_reached) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    result_d[32*(int'(cnt_a_q)*N + int'(cnt_b_q)) +: 32] = dot_res;
                    if (!last_elem) begin
                        if (cnt_b_q == CB_W'(N - 1)) begin
                            cnt_b_d = '0;
                            cnt_a_d = cnt_a_q + 1'b1;
                        end else begin
                            cnt_b_d = cnt_b_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign vec_a  = vec_a_q;
    assign vec_b  = vec_b_q;
    assign result = result_q;

endmodule

// File: tb/tb_matmul_seq_scheduler.sv
// Scoreboard bench for matmul_seq_scheduler with a pipelined integer dot-product unit model.
module tb_matmul_seq_scheduler;

    localparam int L   = 2;
    localparam int M   = 3;
    localparam int N   = 2;
    localparam int DL  = 3;
    localparam int RW  = 32*L*N;
    localparam int AW  = 32*L*M;
    localparam int BW  = 32*N*M;
    localparam int VW  = 32*M;
    localparam int JOB = L*N*(DL+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] A = '0;
    logic [BW-1:0] B_T = '0;
    logic          busy, done;
    logic [VW-1:0] vec_a, vec_b;
    logic [31:0]   dot_res;
    logic [RW-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [RW-1:0] res;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    matmul_seq_scheduler #(.L(L), .M(M), .N(N), .DOT_LAT(DL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B_T(B_T),
        .busy(busy), .done(done), .vec_a(vec_a), .vec_b(vec_b),
        .dot_res(dot_res), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dotv(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [31:0] s = '0;
        for (int k = 0; k < M; k++) s = s + a[32*k +: 32] * b[32*k +: 32];
        return s;
    endfunction

    // Dot unit: result is stable DL-1 edges after its inputs change.
    logic [31:0] d1, d2;
    always @(posedge clk) begin
        d1 <= dotv(vec_a, vec_b);
        d2 <= d1;
    end
    assign dot_res = d2;

    // C(i,j) = sum_k A(i,k) * B(k,j), with B(k,j) stored as B_T(j,k).
    function automatic logic [RW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] bt);
        logic [RW-1:0] r = '0;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < M; k++)
                    r[32*(i*N+j) +: 32] = r[32*(i*N+j) +: 32]
                        + a[32*(i*M+k) +: 32] * bt[32*(j*M+k) +: 32];
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_a();
        logic [AW-1:0] v;
        for (int i = 0; i < L*M; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BW-1:0] rnd_b();
        logic [BW-1:0] v;
        for (int i = 0; i < N*M; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result, mon_e.res);
                check("done_cycle", RW'(cyc), RW'(mon_e.cyc));
            end
        end
    end

    task automatic run_job(input bit hold, input bit chg);
        bit seen = 1'b0;
        @(negedge clk);
        A     = rnd_a();
        B_T   = rnd_b();
        start = 1'b1;
        exp_q.push_back('{model(A, B_T), cyc + 1 + JOB});
        @(negedge clk);
        check("clear_on_start", result, '0);
        check("busy_after_start", RW'(busy), RW'(1));
        if (!hold) start = 1'b0;
        if (chg) A = rnd_a();
        for (int t = 0; t < JOB + 8 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", JOB + 8);
        end
        @(negedge clk);
        check("idle_after_done", RW'(busy), RW'(0));
        start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, RW'(busy), '0);
        check({tag, "_done"}, RW'(done), '0);
        check({tag, "_result"}, result, '0);
        check({tag, "_vec_a"}, RW'(vec_a), '0);
        check({tag, "_vec_b"}, RW'(vec_b), '0);
    endtask

    task automatic reset_mid_job();
        @(negedge clk);
        A     = rnd_a();
        B_T   = rnd_b();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        repeat (4) run_job(1'b0, 1'b0);
        run_job(1'b1, 1'b1);
        run_job(1'b0, 1'b1);
        reset_mid_job();
        repeat (3) run_job(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_drained", RW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_seq_scheduler.md
Name: matmul_seq_scheduler

Overview:
- Sequencing controller for a single shared dot-product unit (VectorMultiplication, VLEN=M), used to compute the matrix product (L x M)·(M x N) one output element at a time.
- Latches operands on a start handshake, then walks the L*N output grid in row-major order.
- Drives the unit's two M-element operand vectors and waits a fixed unit latency before capturing each scalar.
- Raises a one-cycle done pulse when the full L x N result is valid. Sits between the NN layer logic and the shared dot-product datapath.

Parameters:
- L, 1, rows of A and of the result (layer outputs).
- M, 1, shared dimension / dot-product vector length (layer inputs).
- N, 1, columns of B and of the result.
- DOT_LAT, 1, cycles from vec_a/vec_b update to dot_res being valid; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new multiplication; sampled only in IDLE.
- A  in  32*L*M  matrix A, row-major, IEEE-754 single; element (i,k) at [32*(i*M+k) +: 32].
- B_T  in  32*N*M  B transposed, row-major; column j of B at [32*M*j +: 32*M].
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse; result is complete.
- vec_a  out  32*M  to dot-product unit: row cnt_a of latched A.
- vec_b  out  32*M  to dot-product unit: row cnt_b of latched B_T.
- dot_res  in  32  scalar from dot-product unit.
- result  out  32*L*N  product, row-major; element (i,j) at [32*(i*N+j) +: 32].

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0.
  - vec_a, vec_b, result and operand buffers = 0.
  - cnt_a=cnt_b=wait_cnt=0.
- Counters: cnt_a in 0..L-1, cnt_b in 0..N-1, wait_cnt in 0..DOT_LAT-1, each $clog2-sized with a minimum of 1 bit.
- IDLE:
  - If start=1 at an edge: latch A→a_buf and B_T→b_buf; clear result to 0; cnt_a=cnt_b=0; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (busy=1):
  - At the edge: vec_a <= a_buf[32*M*cnt_a +: 32*M]; vec_b <= b_buf[32*M*cnt_b +: 32*M]; wait_cnt <= 0; go to WAIT.
- WAIT (busy=1):
  - If wait_cnt < DOT_LAT-1: increment wait_cnt.
  - Else (wait_cnt == DOT_LAT-1): result[32*(cnt_a*N+cnt_b) +: 32] <= dot_res.
    - Last element (cnt_a==L-1 and cnt_b==N-1): go to DONE.
    - Otherwise advance: if cnt_b==N-1 then cnt_b=0 and cnt_a+=1, else cnt_b+=1; go to LOAD.
- DONE:
  - done=1 and busy=1 for exactly this one cycle; next edge goes to IDLE.
- Timing:
  - Each element takes DOT_LAT+1 cycles.
  - done is high in the cycle starting L*N*(DOT_LAT+1) edges after the start-sampling edge.
- start while not in IDLE (including the DONE cycle) is ignored; it is not queued.
- Changes on A/B_T after acceptance have no effect on the running job.
- result:
  - Holds the last job's values until the next accepted start.
  - Partially written elements are visible while busy; only done guarantees completeness.
- vec_a/vec_b hold their last values in IDLE/DONE.
- The scheduler does no arithmetic; dot_res is passed through unmodified (no width change).
- Reset asserted mid-job: immediate return to the reset state; the partial result is discarded (zeroed).
- Degenerate L=N=1: LOAD → WAIT → DONE; done occurs DOT_LAT+1 edges after start.

Test Plan:
- Dot product: L=2, M=2, N=1, DOT_LAT=1 with a real VectorMultiplication.
  - Stimulus: A={1.0,2.0;3.0,4.0} (3F800000,40000000,40400000,40800000), B_T={1.0,1.0}, start pulse.
  - Expected: done exactly 4 edges after start; result[31:0]=40400000 (3.0), result[63:32]=40E00000 (7.0).
- Row-major walk: L=2, M=1, N=2, A={2.0,3.0}, B_T={1.0,4.0}.
  - Expected: vec_a/vec_b sequence (2,1),(2,4),(3,1),(3,4); result={2.0,8.0,3.0,12.0}={40000000,41000000,40400000,41400000}.
- Latency parameter: DOT_LAT=3 with a 3-stage delayed model unit, L=N=1.
  - Expected: capture on the 4th edge after start, done on the same cycle count (4); no earlier sample of dot_res.
- start held high for the whole job, and A changed mid-job.
  - Expected: exactly one done pulse; result uses the latched A; a new job starts only on the edge after DONE returns to IDLE.
- Reset mid-job: assert rst_n=0 while in WAIT of element 1.
  - Expected: busy=0, done=0, result=0, vec_a=vec_b=0 immediately (asynchronously); after release, a fresh start completes normally.
- Back-to-back jobs with different A.
  - Expected: result cleared to 0 on the second start; the second done shows only the new values.
